inst_fetch: RTL and testbench

INST_FETCH -- requirements
Module: inst_fetch

---
 rtl/inst_fetch_pkg.sv | 6 +
 rtl/inst_fetch.sv | 67 ++++++
 tb/tb_inst_fetch.sv | 145 ++++++++++++++
 3 files changed

// File: rtl/inst_fetch_pkg.sv
// inst_fetch_pkg: shared constants and FSM encoding for the instruction fetch unit
package inst_fetch_pkg;
  localparam int XLEN = 32;
  localparam logic [XLEN-1:0] RESET_PC_DEFAULT = 32'h8000_0000;
  typedef enum logic [1:0] {S_REQ, S_WAIT, S_DROP, S_HOLD} state_t;
endpackage

// File: rtl/inst_fetch.sv
// inst_fetch: single-outstanding instruction fetch with redirect and stale-response drop
module inst_fetch
  import inst_fetch_pkg::*;
#(
  parameter logic [XLEN-1:0] RESET_PC = RESET_PC_DEFAULT
) (
  input  logic            clk,
  input  logic            rst,
  output logic            req_valid,
  input  logic            req_ready,
  output logic [XLEN-1:0] req_addr,
  input  logic            resp_valid,
  input  logic [XLEN-1:0] resp_data,
  output logic            inst_valid,
  input  logic            inst_ready,
  output logic [XLEN-1:0] inst,
  output logic [XLEN-1:0] inst_pc,
  input  logic            redirect_valid,
  input  logic [XLEN-1:0] redirect_pc
);
  state_t state;
  logic [XLEN-1:0] pc;
  logic [XLEN-1:0] tgt;
  assign tgt        = {redirect_pc[XLEN-1:2], 2'b00};
  // gated by rst so nothing is requested while reset is held
  assign req_valid  = (state == S_REQ) && !rst;
  assign req_addr   = pc;
  assign inst_valid = (state == S_HOLD);
  always_ff @(posedge clk) begin
    if (rst) begin
      state   <= S_REQ;
      pc      <= {RESET_PC[XLEN-1:2], 2'b00};
      inst    <= '0;
      inst_pc <= RESET_PC;
    end else begin
      case (state)
        S_REQ: begin
          if (redirect_valid) pc <= tgt;
          if (req_ready) state <= redirect_valid ? S_DROP : S_WAIT;
        end
        S_WAIT: begin
          if (redirect_valid) begin
            pc    <= tgt;
            state <= resp_valid ? S_REQ : S_DROP;
          end else if (resp_valid) begin
            inst    <= resp_data;
            inst_pc <= pc;
            state   <= S_HOLD;
          end
        end
        S_DROP: begin
          if (redirect_valid) pc <= tgt;
          if (resp_valid) state <= S_REQ;
        end
        default: begin
          if (redirect_valid) begin
            pc    <= tgt;
            state <= S_REQ;
          end else if (inst_ready) begin
            pc    <= pc + XLEN'(4);
            state <= S_REQ;
          end
        end
      endcase
    end
  end
endmodule

// File: tb/tb_inst_fetch.sv
// tb_inst_fetch: directed and randomized checks of inst_fetch against a transaction-level model
module tb_inst_fetch;
  localparam logic [31:0] RPC = 32'h8000_0000;
  logic clk = 1'b0, rst = 1'b1;
  logic req_valid, req_ready = 1'b0, resp_valid = 1'b0, inst_valid, inst_ready = 1'b0, redirect_valid = 1'b0;
  logic [31:0] req_addr, resp_data = '0, inst, inst_pc, redirect_pc = '0;
  int checks = 0, errors = 0;
  logic [31:0] m_pc = RPC, out_addr = '0, e_inst = '0, e_pc = '0, mem_addr = '0;
  logic out_valid = 1'b0, out_live = 1'b0, have_inst = 1'b0, mem_en = 1'b0, mem_busy = 1'b0;
  int mem_delay = 0;

  inst_fetch #(.RESET_PC(RPC)) dut (
    .clk(clk), .rst(rst), .req_valid(req_valid), .req_ready(req_ready), .req_addr(req_addr),
    .resp_valid(resp_valid), .resp_data(resp_data), .inst_valid(inst_valid), .inst_ready(inst_ready),
    .inst(inst), .inst_pc(inst_pc), .redirect_valid(redirect_valid), .redirect_pc(redirect_pc)
  );

  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    assert (got === exp) else begin
      errors++;
      $error("FAIL %s observed %h expected %h", tag, got, exp);
    end
  endtask

  task automatic check();
    logic exp_req;
    exp_req = !rst && !out_valid && !have_inst;
    chk("req_valid", 32'(req_valid), 32'(exp_req));
    chk("inst_valid", 32'(inst_valid), 32'(have_inst));
    if (exp_req) chk("req_addr", req_addr, m_pc);
    if (have_inst) begin
      chk("inst", inst, e_inst);
      chk("inst_pc", inst_pc, e_pc);
    end
  endtask

  // Fetch as transactions: an outstanding committed request that is live or stale, and a held instruction.
  task automatic model_update();
    logic [31:0] tgt;
    tgt = {redirect_pc[31:2], 2'b00};
    if (rst) begin
      m_pc = RPC; out_valid = 0; have_inst = 0; mem_busy = 0;
    end else if (have_inst) begin
      if (redirect_valid) begin have_inst = 0; m_pc = tgt; end
      else if (inst_ready) begin have_inst = 0; m_pc = m_pc + 32'd4; end
    end else if (out_valid) begin
      if (resp_valid) begin
        out_valid = 0;
        if (out_live && !redirect_valid) begin have_inst = 1; e_inst = resp_data; e_pc = out_addr; end
      end
      if (redirect_valid) begin m_pc = tgt; out_live = 0; end
    end else begin
      if (req_ready) begin
        out_valid = 1; out_live = !redirect_valid; out_addr = m_pc;
        if (mem_en) begin mem_busy = 1; mem_addr = m_pc; mem_delay = $urandom_range(0, 3); end
      end
      if (redirect_valid) m_pc = tgt;
    end
  endtask

  task automatic tick();
    model_update();
    @(negedge clk);
    check();
  endtask

  task automatic mem_drive();
    resp_valid = 1'b0;
    resp_data = $urandom;
    if (mem_busy) begin
      if (mem_delay == 0) begin
        resp_valid = 1'b1;
        resp_data = mem_addr ^ 32'h5A5A_0413;
        mem_busy = 1'b0;
      end else mem_delay--;
    end
  endtask

  initial begin
    tick(); tick();
    chk("rst_inst", inst, 32'h0);
    chk("rst_inst_pc", inst_pc, RPC);
    // reset release and basic fetch
    rst = 0; #1 check();
    chk("t32_addr", req_addr, 32'h8000_0000);
    req_ready = 1; tick();
    req_ready = 0; resp_valid = 1; resp_data = 32'h0000_0413; tick();
    resp_valid = 0;
    chk("t32_inst", inst, 32'h0000_0413);
    chk("t32_pc", inst_pc, 32'h8000_0000);
    // stall in HOLD
    repeat (5) begin
      tick();
      chk("t33_inst", inst, 32'h0000_0413);
      chk("t33_req", 32'(req_valid), 32'h0);
    end
    inst_ready = 1; tick(); inst_ready = 0;
    chk("t32_next", req_addr, 32'h8000_0004);
    // redirect while waiting, late response discarded
    req_ready = 1; tick(); req_ready = 0;
    redirect_valid = 1; redirect_pc = 32'h8000_0100; tick(); redirect_valid = 0;
    tick(); tick();
    resp_valid = 1; resp_data = 32'hDEAD_BEEF; tick(); resp_valid = 0;
    chk("t34_iv", 32'(inst_valid), 32'h0);
    chk("t34_addr", req_addr, 32'h8000_0100);
    // redirect in HOLD overrides pc+4
    req_ready = 1; tick(); req_ready = 0;
    resp_valid = 1; resp_data = 32'h1234_5678; tick(); resp_valid = 0;
    inst_ready = 1; redirect_valid = 1; redirect_pc = 32'h8000_0203; tick();
    inst_ready = 0; redirect_valid = 0;
    chk("t35_addr", req_addr, 32'h8000_0200);
    // pc wrap
    redirect_valid = 1; redirect_pc = 32'hFFFF_FFFC; tick(); redirect_valid = 0;
    chk("t36_top", req_addr, 32'hFFFF_FFFC);
    req_ready = 1; tick(); req_ready = 0;
    resp_valid = 1; resp_data = 32'h0000_0013; tick(); resp_valid = 0;
    chk("t36_pc", inst_pc, 32'hFFFF_FFFC);
    inst_ready = 1; tick(); inst_ready = 0;
    chk("t36_wrap", req_addr, 32'h0000_0000);
    // reset while waiting, stale response after reset ignored
    req_ready = 1; tick(); req_ready = 0;
    rst = 1; tick(); rst = 0;
    resp_valid = 1; resp_data = 32'hBAD0_BAD0; #1 check();
    chk("t37_addr0", req_addr, RPC);
    tick(); resp_valid = 0;
    chk("t37_iv", 32'(inst_valid), 32'h0);
    chk("t37_addr", req_addr, RPC);
    // randomized traffic
    mem_en = 1;
    for (int i = 0; i < 4000; i++) begin
      rst = ($urandom_range(0, 299) == 0);
      req_ready = ($urandom_range(0, 2) != 0);
      inst_ready = $urandom_range(0, 1) == 1;
      redirect_valid = ($urandom_range(0, 9) == 0);
      redirect_pc = ($urandom_range(0, 3) == 0) ? (32'hFFFF_FFF0 | 32'($urandom_range(0, 15))) : $urandom;
      mem_drive();
      tick();
    end
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end
endmodule
